// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared op encoding, S1 entry type and op decode helpers for the multiply issue path
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_W    = 2'd0,
        MULH_W   = 2'd1,
        MULH_WU  = 2'd2,
        MUL_RSVD = 2'd3
    } mul_op_t;

    localparam logic [1:0] MUL_W_OP   = 2'd0;
    localparam logic [1:0] MULH_W_OP  = 2'd1;
    localparam logic [1:0] MULH_WU_OP = 2'd2;

    typedef struct packed {
        mul_op_t     op;
        logic [31:0] x;
        logic [31:0] y;
    } mul_s1_t;

    // The reserved encoding decodes exactly like MUL_W: signed, low word.
    function automatic logic mul_op_is_signed(mul_op_t op);
        return op != MULH_WU;
    endfunction

    function automatic logic mul_op_is_high(mul_op_t op);
        return (op == MULH_W) || (op == MULH_WU);
    endfunction

endpackage

// File: rtl/mul_last_cache.sv
// rtl/mul_last_cache.sv - single-entry store of the last multiplier operands and 64-bit product with hit compare
module mul_last_cache (
    input  logic        clk,
    input  logic        rst,
    input  logic        upd,
    input  logic [31:0] upd_x,
    input  logic [31:0] upd_y,
    input  logic        upd_signed,
    input  logic [63:0] upd_prod,
    input  logic [31:0] look_x,
    input  logic [31:0] look_y,
    input  logic        look_signed,
    output logic        hit,
    output logic [63:0] prod
);

    logic        cache_valid;
    logic [31:0] cache_x;
    logic [31:0] cache_y;
    logic        cache_signed;
    logic [63:0] cache_prod;

    // Only reset invalidates the entry; a flush leaves a correct product behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid  <= 1'b0;
            cache_x      <= '0;
            cache_y      <= '0;
            cache_signed <= 1'b0;
            cache_prod   <= '0;
        end else if (upd) begin
            cache_valid  <= 1'b1;
            cache_x      <= upd_x;
            cache_y      <= upd_y;
            cache_signed <= upd_signed;
            cache_prod   <= upd_prod;
        end
    end

    assign hit  = cache_valid && (cache_x == look_x) && (cache_y == look_y)
                  && (cache_signed == look_signed);
    assign prod = cache_prod;

endmodule

// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - two-stage issue/capture controller around the combinational 32x32 multiplier
// Optional last-product bypass enabled by defining MUL_LAST_PRODUCT_CACHE_EN.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       in_op_i,
    input  logic [31:0]      in_x_i,
    input  logic [31:0]      in_y_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_data_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             mul_signed_o,
    output logic [31:0]      mul_x_o,
    output logic [31:0]      mul_y_o,
    input  logic [63:0]      mul_res_i
);

    mul_s1_t          s1_q;
    logic             s1_valid;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;
    logic [31:0]      s2_data;
    logic [TAG_W-1:0] s2_tag;

    mul_op_t          in_op;
    logic             s2_free;
    logic             in_fire;
    logic             s1_adv;
    logic             byp;
    logic [31:0]      byp_data;
    logic [31:0]      res_word;

    assign in_op      = mul_op_t'(in_op_i);
    assign s2_free    = !s2_valid || out_ready_i;
    assign in_ready_o = !flush_i && (!s1_valid || s2_free);
    assign in_fire    = in_valid_i && in_ready_o;
    assign s1_adv     = s1_valid && s2_free;
    assign res_word   = mul_op_is_high(s1_q.op) ? mul_res_i[63:32] : mul_res_i[31:0];

`ifdef MUL_LAST_PRODUCT_CACHE_EN
    logic        cache_hit;
    logic [63:0] cache_prod;

    mul_last_cache u_cache (
        .clk         (clk),
        .rst         (rst),
        .upd         (s1_adv && !flush_i),
        .upd_x       (s1_q.x),
        .upd_y       (s1_q.y),
        .upd_signed  (mul_op_is_signed(s1_q.op)),
        .upd_prod    (mul_res_i),
        .look_x      (in_x_i),
        .look_y      (in_y_i),
        .look_signed (mul_op_is_signed(in_op)),
        .hit         (cache_hit),
        .prod        (cache_prod)
    );

    // Bypass only into an empty S1 so the hit cannot overtake an older op.
    assign byp      = in_fire && cache_hit && !s1_valid && s2_free;
    assign byp_data = mul_op_is_high(in_op) ? cache_prod[63:32] : cache_prod[31:0];
`else
    assign byp      = 1'b0;
    assign byp_data = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_tag   <= '0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (in_fire && !byp) begin
                s1_valid <= 1'b1;
                s1_q     <= '{op: in_op, x: in_x_i, y: in_y_i};
                s1_tag   <= in_tag_i;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_adv) begin
                s2_valid <= 1'b1;
                s2_data  <= res_word;
                s2_tag   <= s1_tag;
            end else if (byp) begin
                s2_valid <= 1'b1;
                s2_data  <= byp_data;
                s2_tag   <= in_tag_i;
            end else if (out_ready_i) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // Signedness is gated by s1_valid so an idle multiplier sees all-zero controls.
    assign mul_signed_o = s1_valid && mul_op_is_signed(s1_q.op);
    assign mul_x_o      = s1_q.x;
    assign mul_y_o      = s1_q.y;
    assign out_valid_o  = s2_valid;
    assign out_data_o   = s2_data;
    assign out_tag_o    = s2_tag;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb/tb_mul_issue_ctrl.sv - directed self-checking bench for mul_issue_ctrl with a behavioural multiplier
module tb_mul_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        mul_signed;
    logic [31:0] mul_x;
    logic [31:0] mul_y;
    logic [63:0] mul_res;

    int checks = 0;
    int fails  = 0;

    mul_issue_ctrl #(.TAG_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_op_i      (in_op),
        .in_x_i       (in_x),
        .in_y_i       (in_y),
        .in_tag_i     (in_tag),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_tag_o    (out_tag),
        .mul_signed_o (mul_signed),
        .mul_x_o      (mul_x),
        .mul_y_o      (mul_y),
        .mul_res_i    (mul_res)
    );

    assign mul_res = mul_signed ? ({{32{mul_x[31]}}, mul_x} * {{32{mul_y[31]}}, mul_y})
                                : ({32'b0, mul_x} * {32'b0, mul_y});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_x     = x;
        in_y     = y;
        in_tag   = tag;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'd0 || in_ready !== 1'b1
            || mul_x !== 32'h0 || mul_y !== 32'h0 || mul_signed !== 1'b0) begin
            fails++;
            $display("FAIL reset: got valid=%b data=%h tag=%0d ready=%b x=%h y=%h sgn=%b, want 0 0 0 1 0 0 0",
                     out_valid, out_data, out_tag, in_ready, mul_x, mul_y, mul_signed);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops [3];
        logic [31:0] exp_d [3];
        ops[0] = 2'd0; ops[1] = 2'd1; ops[2] = 2'd2;
        exp_d[0] = 32'h00000001; exp_d[1] = 32'h00000000; exp_d[2] = 32'hFFFFFFFE;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i < 3) drive(ops[i], 32'hFFFFFFFF, 32'hFFFFFFFF, 5'(i + 1));
            else in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (i >= 2 && i < 5) begin
                if (out_valid !== 1'b1 || out_data !== exp_d[i-2] || out_tag !== 5'(i - 1)) begin
                    fails++;
                    $display("FAIL back_to_back[%0d]: got valid=%b data=%h tag=%0d, want 1 %h %0d",
                             i, out_valid, out_data, out_tag, exp_d[i-2], i - 1);
                end
            end else if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL back_to_back_idle[%0d]: got valid=%b, want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_signed_ops();
        logic [1:0]  ops [6];
        logic [31:0] xs [6];
        logic [31:0] ys [6];
        logic [31:0] exp_d [6];
        ops[0] = 2'd0; xs[0] = 32'd7;         ys[0] = 32'hFFFFFFFD; exp_d[0] = 32'hFFFFFFEB;
        ops[1] = 2'd1; xs[1] = 32'd7;         ys[1] = 32'hFFFFFFFD; exp_d[1] = 32'hFFFFFFFF;
        ops[2] = 2'd2; xs[2] = 32'd7;         ys[2] = 32'hFFFFFFFD; exp_d[2] = 32'h00000006;
        ops[3] = 2'd1; xs[3] = 32'h80000000;  ys[3] = 32'h80000000; exp_d[3] = 32'h40000000;
        ops[4] = 2'd0; xs[4] = 32'h80000000;  ys[4] = 32'h80000000; exp_d[4] = 32'h00000000;
        ops[5] = 2'd3; xs[5] = 32'd7;         ys[5] = 32'hFFFFFFFD; exp_d[5] = 32'hFFFFFFEB;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i < 6) drive(ops[i], xs[i], ys[i], 5'(i + 10));
            else in_valid = 1'b0;
            @(negedge clk);
            if (i >= 1 && i <= 6) begin
                checks++;
                if (mul_signed !== (ops[i-1] != 2'd2)) begin
                    fails++;
                    $display("FAIL mul_signed[%0d]: got %b, want %b", i, mul_signed, ops[i-1] != 2'd2);
                end
            end
            if (i >= 2 && i < 8) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_d[i-2] || out_tag !== 5'(i + 8)) begin
                    fails++;
                    $display("FAIL signed_ops[%0d]: got valid=%b data=%h tag=%0d, want 1 %h %0d",
                             i - 2, out_valid, out_data, out_tag, exp_d[i-2], i + 8);
                end
            end
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        tick(); drive(2'd0, 32'd2, 32'd5, 5'd1); @(negedge clk);
        tick(); drive(2'd0, 32'd3, 32'd5, 5'd2); @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL stall_second_ready: got %b, want 1", in_ready);
        end
        tick(); drive(2'd0, 32'd4, 32'd5, 5'd3); @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 5'd1 || out_data !== 32'd10) begin
            fails++;
            $display("FAIL stall_full: got ready=%b valid=%b tag=%0d data=%h, want 0 1 1 0000000a",
                     in_ready, out_valid, out_tag, out_data);
        end
        tick(); @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 5'd1 || out_data !== 32'd10) begin
            fails++;
            $display("FAIL stall_hold: got ready=%b valid=%b tag=%0d data=%h, want 0 1 1 0000000a",
                     in_ready, out_valid, out_tag, out_data);
        end
        tick(); out_ready = 1'b1; @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_tag !== 5'd1) begin
            fails++; $display("FAIL stall_release: got ready=%b tag=%0d, want 1 1", in_ready, out_tag);
        end
        tick(); in_valid = 1'b0; @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 5'd2 || out_data !== 32'd15) begin
            fails++;
            $display("FAIL stall_drain2: got valid=%b tag=%0d data=%h, want 1 2 0000000f", out_valid, out_tag, out_data);
        end
        tick(); @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 5'd3 || out_data !== 32'd20) begin
            fails++;
            $display("FAIL stall_drain3: got valid=%b tag=%0d data=%h, want 1 3 00000014", out_valid, out_tag, out_data);
        end
        tick(); @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL stall_empty: got valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        tick(); drive(2'd0, 32'd6, 32'd7, 5'd4); @(negedge clk);
        tick(); drive(2'd0, 32'd8, 32'd9, 5'd5); @(negedge clk);
        tick(); drive(2'd0, 32'd1, 32'd1, 5'd9); flush = 1'b1; @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 5'd4) begin
            fails++;
            $display("FAIL flush_cycle: got ready=%b valid=%b tag=%0d, want 0 1 4", in_ready, out_valid, out_tag);
        end
        tick(); flush = 1'b0; in_valid = 1'b0; @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL flush_cleared: got valid=%b tag=%0d, want valid 0", out_valid, out_tag);
        end
        tick(); @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL flush_no_stale: got valid=%b tag=%0d, want valid 0", out_valid, out_tag);
        end
        tick(); drive(2'd0, 32'd10, 32'd11, 5'd6); @(negedge clk);
        tick(); in_valid = 1'b0; @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL flush_after_early: got valid=%b, want 0", out_valid);
        end
        tick(); @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd110 || out_tag !== 5'd6) begin
            fails++;
            $display("FAIL flush_after: got valid=%b data=%h tag=%0d, want 1 0000006e 6", out_valid, out_data, out_tag);
        end
        tick(); @(negedge clk);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        tick(); drive(2'd0, 32'd2, 32'd3, 5'd7); @(negedge clk);
        tick(); drive(2'd0, 32'd4, 32'd5, 5'd8); @(negedge clk);
        tick(); in_valid = 1'b0; @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            fails++; $display("FAIL rst_mid_full: got ready=%b valid=%b, want 0 1", in_ready, out_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1 || mul_x !== 32'h0) begin
            fails++;
            $display("FAIL rst_mid_async: got valid=%b data=%h ready=%b x=%h, want 0 0 1 0",
                     out_valid, out_data, in_ready, mul_x);
        end
        tick(); rst = 1'b0; out_ready = 1'b1;
        tick(); drive(2'd2, 32'hFFFFFFFF, 32'd2, 5'd9); @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL rst_mid_accept: got valid=%b ready=%b, want 0 1", out_valid, in_ready);
        end
        tick(); in_valid = 1'b0; @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL rst_mid_lat1: got valid=%b, want 0", out_valid);
        end
        tick(); @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h1 || out_tag !== 5'd9) begin
            fails++;
            $display("FAIL rst_mid_lat2: got valid=%b data=%h tag=%0d, want 1 00000001 9", out_valid, out_data, out_tag);
        end
        tick(); @(negedge clk);
    endtask

    task automatic test_cache();
        logic hit_on;
`ifdef MUL_LAST_PRODUCT_CACHE_EN
        hit_on = 1'b1;
`else
        hit_on = 1'b0;
`endif
        out_ready = 1'b1;
        tick(); drive(2'd1, 32'd3, 32'd5, 5'd10); @(negedge clk);
        tick(); in_valid = 1'b0;
        tick(); tick(); tick(); @(negedge clk);
        tick(); drive(2'd0, 32'd3, 32'd5, 5'd11); @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL cache_accept: got valid=%b, want 0", out_valid);
        end
        tick(); in_valid = 1'b0; @(negedge clk);
        checks++;
        if (out_valid !== hit_on || (hit_on && (out_data !== 32'hF || out_tag !== 5'd11))) begin
            fails++;
            $display("FAIL cache_lat1: got valid=%b data=%h tag=%0d, want valid=%b data 0000000f tag 11",
                     out_valid, out_data, out_tag, hit_on);
        end
        tick(); @(negedge clk);
        checks++;
        if (out_valid !== !hit_on || (!hit_on && (out_data !== 32'hF || out_tag !== 5'd11))) begin
            fails++;
            $display("FAIL cache_lat2: got valid=%b data=%h tag=%0d, want valid=%b data 0000000f tag 11",
                     out_valid, out_data, out_tag, !hit_on);
        end
        tick(); drive(2'd2, 32'd3, 32'd5, 5'd12); @(negedge clk);
        tick(); in_valid = 1'b0; @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL cache_miss_lat1: got valid=%b, want 0", out_valid);
        end
        tick(); @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0 || out_tag !== 5'd12) begin
            fails++;
            $display("FAIL cache_miss_lat2: got valid=%b data=%h tag=%0d, want 1 00000000 12", out_valid, out_data, out_tag);
        end
        tick(); @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_x      = 32'h0;
        in_y      = 32'h0;
        in_tag    = 5'd0;
        out_ready = 1'b1;
        test_reset();
        test_back_to_back();
        test_signed_ops();
        test_stall();
        test_flush();
        test_reset_mid();
        test_cache();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
